// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, default-width queue entry layout, and a
// PC alignment helper. The entry gains a fault bit when
// FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int INSN_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // queue lacks space, nothing offered
    REQ  = 2'd1,  // request offered to instruction memory
    WAIT = 2'd2,  // one request outstanding
    DROP = 2'd3   // outstanding response belongs to a flushed path
  } fetch_state_e;

  // Entry layout at default widths; the queue packs the same field order
  // (pc in the MSBs, then insn, then the optional fault bit).
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INSN_W_DEF-1:0] insn;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                  fault;
`endif
  } fetch_entry_t;

  // A PC is word-aligned when its two low bits are clear.
  function automatic logic misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO with a registered head and flush.
// Latency: a push into an empty FIFO shows on head_vld/head_dat next cycle.
// Backpressure: caller must not push when full unless popping the same cycle.
//
// Ports: clock, reset (async active-low), push_vld/push_dat (write),
// pop (consume head, ignored when empty), flush (clear all, wins over
// push/pop), count (occupancy), head_vld/head_dat (registered head entry).
module fetch_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_vld,
  output logic [WIDTH-1:0]             head_dat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr, rptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push, do_pop, head_from_push;

  assign do_pop  = pop && head_vld && !flush;
  assign do_push = push_vld && !flush;

  always_comb begin
    count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    rptr_nxt  = rptr + PTR_W'(do_pop);
    // The pushed word becomes the head only when nothing older survives
    // this cycle's pop; otherwise the head comes from storage, which
    // already holds it.
    head_from_push = do_push &&
                     ((count == '0) || ((count == CNT_W'(1)) && do_pop));
    if (flush) begin
      count_nxt = '0;
      rptr_nxt  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      head_dat <= '0;
    end else begin
      count    <= count_nxt;
      rptr     <= rptr_nxt;
      head_vld <= (count_nxt != '0);
      if (flush)
        wptr <= '0;
      else if (do_push)
        wptr <= wptr + PTR_W'(1);
      if (count_nxt != '0)
        head_dat <= head_from_push ? push_dat : mem[rptr_nxt];
    end
  end

  // Storage needs no reset; occupancy and the head register gate its use.
  always_ff @(posedge clock) begin
    if (do_push)
      mem[wptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: one imem read at a time, results queued with their PC.
// Latency: request handshake in N, response N+1 earliest, if_valid in N+2.
// Backpressure: holds the PC (pc_stall) when the queue lacks space or imem stalls.
//
// Ports: clock, reset (async active-low); pc_in/pc_stall to the next-PC
// mux; flush redirect pulse; imem_req_valid/ready/addr and
// imem_rsp_valid/data to instruction memory; if_valid/ready/insn/pc to
// decode. Optional macro FETCH_MISALIGN_CHECK_EN adds if_fault and turns
// misaligned PCs into fault entries instead of memory reads.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSN_W = INSN_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  input  logic              flush,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INSN_W-1:0] if_insn,
  output logic [ADDR_W-1:0] if_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              if_fault
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH-1);
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam int ENTRY_W = ADDR_W + INSN_W + 1;
`else
  localparam int ENTRY_W = ADDR_W + INSN_W;
`endif

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pend_pc;
  logic [CNT_W-1:0]   count;
  logic               pop, space, space_after, misalign;
  logic               handshake, rsp_push, fault_push, push;
  logic [ENTRY_W-1:0] push_dat, head_dat;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = misaligned(pc_in[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign pop = if_valid && if_ready;
  // Space now, and space left after a push this cycle. WAIT is only ever
  // entered with a slot free, so a push plus pop always leaves room.
  assign space       = (count < DEPTH_C)  || pop;
  assign space_after = (count < DEPTH_M1) || pop;

  // The request is withdrawn in the flush cycle: pc_in is about to change.
  assign imem_req_valid = (state == REQ) && !flush && !misalign;
  assign imem_addr      = pc_in;
  assign handshake      = imem_req_valid && imem_req_ready;
  assign fault_push     = (state == REQ) && !flush && misalign;
  assign rsp_push       = (state == WAIT) && imem_rsp_valid && !flush;
  assign push           = rsp_push || fault_push;
  // The PC advances exactly when the current one has been consumed.
  assign pc_stall       = !(handshake || fault_push);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign push_dat = fault_push ? {pc_in, {INSN_W{1'b0}}, 1'b1}
                               : {pend_pc, imem_rsp_data, 1'b0};
  assign if_fault = head_dat[0];
`else
  assign push_dat = {pend_pc, imem_rsp_data};
`endif

  assign if_pc   = head_dat[ENTRY_W-1 -: ADDR_W];
  assign if_insn = head_dat[ENTRY_W-ADDR_W-1 -: INSN_W];

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flush),
    .count    (count),
    .head_vld (if_valid),
    .head_dat (head_dat)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pend_pc <= '0;
    end else begin
      if (handshake)
        pend_pc <= pc_in;
      case (state)
        IDLE: if (flush || space) state <= REQ;
        REQ: begin
          if (handshake)
            state <= WAIT;
          else if (fault_push)
            state <= space_after ? REQ : IDLE;
        end
        WAIT: begin
          // A response coinciding with flush is simply not pushed.
          if (imem_rsp_valid)
            state <= (flush || space_after) ? REQ : IDLE;
          else if (flush)
            state <= DROP;
        end
        DROP: if (imem_rsp_valid) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int ADDR_W = 64;
  localparam int INSN_W = 32;
  localparam int DEPTH  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_stall;
  logic              flush;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [INSN_W-1:0] imem_rsp_data;
  logic              if_valid;
  logic              if_ready;
  logic [INSN_W-1:0] if_insn;
  logic [ADDR_W-1:0] if_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              if_fault;
`endif

  fetch_queue #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_stall       (pc_stall),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_insn        (if_insn),
    .if_pc          (if_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .if_fault       (if_fault)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int nchk = 0;
  int nerr = 0;

  // Environment knobs (percent for ready lines, per mille for flush).
  int rdy_pct, dec_pct, lat_min, lat_max, flush_pml;
  bit flush_req;
  logic [63:0] flush_target;

  // PC register model and expected in-order stream seen by decode.
  logic [63:0] pc_reg, exp_pc;

  // Instruction memory model: one outstanding read, fixed data per address.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;

  bit          hs;
  logic [63:0] hs_addr;
  int          npop, nreq;
  bit          prev_flush, prev_req_stuck, prev_head_stuck;
  logic [63:0] prev_addr, prev_if_pc;
  logic [31:0] prev_if_insn;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [63:0] a);
    logic [31:0] lo, hi;
    lo = a[31:0];
    hi = a[63:32];
    return 32'h8B020020 ^ (lo * 32'h9E3779B1) ^ hi;
  endfunction

  // One clock cycle: drive inputs at the falling edge, sample 1ns later,
  // then advance the environment models for the coming rising edge.
  task automatic step();
    bit          fl;
    logic [31:0] ei;
    @(negedge clock);
    pc_in          = pc_reg;
    imem_rsp_valid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data;
        mem_busy       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if_ready       = ($urandom_range(99) < dec_pct);
    fl = flush_req;
    if (!fl && ($urandom_range(999) < flush_pml)) begin
      fl = 1'b1;
      flush_target = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
    end
    flush     = fl;
    flush_req = 1'b0;
    #1;
    if (prev_flush) chk("flush_clears_queue", if_valid, 1'b0);
    if (prev_req_stuck && !flush) begin
      chk("req_held_valid", imem_req_valid, 1'b1);
      chk("req_held_addr", imem_addr, prev_addr);
    end
    if (prev_head_stuck) begin
      chk("head_held_pc", if_pc, prev_if_pc);
      chk("head_held_insn", if_insn, prev_if_insn);
    end
    if (imem_req_valid) chk("addr_is_pc", imem_addr, pc_in);
    hs = imem_req_valid && imem_req_ready;
    if (hs) begin
      chk("one_outstanding", mem_busy, 1'b0);
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
      mem_data = insn_of(imem_addr);
      hs_addr  = imem_addr;
      nreq++;
    end
    if (if_valid && if_ready) begin
      ei = insn_of(exp_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (exp_pc[1:0] != 2'b00) ei = 32'h0;
      chk("pop_fault", if_fault, exp_pc[1:0] != 2'b00);
`endif
      chk("pop_pc", if_pc, exp_pc);
      chk("pop_insn", if_insn, ei);
      exp_pc += 64'd4;
      npop++;
    end
    if (flush) begin
      pc_reg = flush_target;
      exp_pc = flush_target;
    end else if (!pc_stall) begin
      pc_reg += 64'd4;
    end
    prev_flush      = flush;
    prev_req_stuck  = imem_req_valid && !imem_req_ready;
    prev_addr       = imem_addr;
    prev_head_stuck = if_valid && !if_ready && !flush;
    prev_if_pc      = if_pc;
    prev_if_insn    = if_insn;
  endtask

  initial begin
    bit found;
    reset = 1'b0; pc_in = '0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    pc_reg = '0; exp_pc = '0; flush_req = 1'b0; flush_target = '0;
    rdy_pct = 100; dec_pct = 0; lat_min = 1; lat_max = 1; flush_pml = 0;
    mem_busy = 1'b0; mem_cnt = 0; mem_data = '0; hs = 1'b0; hs_addr = '0;
    npop = 0; nreq = 0; prev_flush = 1'b0; prev_req_stuck = 1'b0;
    prev_head_stuck = 1'b0; prev_addr = '0; prev_if_pc = '0; prev_if_insn = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_pc_stall", pc_stall, 1'b1);
    chk("rst_if_pc", if_pc, 64'h0);
    chk("rst_if_insn", if_insn, 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;

    // First fetch from PC 0 with a 1-cycle memory; decode stalled.
    step(); chk("c1_no_req", imem_req_valid, 1'b0); chk("c1_stall", pc_stall, 1'b1);
    step(); chk("c2_req", imem_req_valid, 1'b1); chk("c2_addr", imem_addr, 64'h0);
    chk("c2_stall", pc_stall, 1'b0);
    step(); chk("c3_not_visible", if_valid, 1'b0);
    step(); chk("c4_valid", if_valid, 1'b1); chk("c4_pc", if_pc, 64'h0);
    chk("c4_insn", if_insn, 32'h8B020020);
    step();
    // Queue holds 0x0 and 0x4: no more requests, PC held at 0x8.
    repeat (3) begin
      step();
      chk("full_no_req", imem_req_valid, 1'b0);
      chk("full_stall", pc_stall, 1'b1);
    end
    chk("full_pc_held", pc_in, 64'h8);
    dec_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (hs) begin found = 1'b1; chk("resume_addr", hs_addr, 64'h8); end
    end
    if (!found) chk("resume_timeout", 1'b0, 1'b1);

    // Memory not ready for 3 cycles at PC 0x10.
    rdy_pct = 0;
    repeat (6) step();
    flush_target = 64'h10; flush_req = 1'b1; step();
    repeat (3) begin
      step();
      chk("rdy_low_req", imem_req_valid, 1'b1);
      chk("rdy_low_addr", imem_addr, 64'h10);
      chk("rdy_low_stall", pc_stall, 1'b1);
    end
    rdy_pct = 100;
    step(); chk("accept_10", hs ? hs_addr : 64'hFFFF_FFFF_FFFF_FFFF, 64'h10);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (hs) begin found = 1'b1; chk("next_after_10", hs_addr, 64'h14); end
    end
    if (!found) chk("next_after_10_timeout", 1'b0, 1'b1);

    // Flush while waiting; stale response arrives two cycles later.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = hs;
    end
    if (!found) chk("t4_hs_timeout", 1'b0, 1'b1);
    flush_target = 64'h100; flush_req = 1'b1; step();
    step(); chk("drop_no_req1", imem_req_valid, 1'b0);
    step(); chk("drop_stale_rsp", imem_rsp_valid, 1'b1);
    chk("drop_no_req2", imem_req_valid, 1'b0);
    step(); chk("redirect_req", imem_req_valid, 1'b1); chk("redirect_addr", imem_addr, 64'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (if_valid) begin found = 1'b1; chk("redirect_if_pc", if_pc, 64'h100); end
    end
    if (!found) chk("redirect_timeout", 1'b0, 1'b1);

    // Flush coinciding with the response that would fill the queue.
    dec_pct = 0; lat_min = 2; lat_max = 2;
    flush_target = 64'h180; flush_req = 1'b1; step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = hs && (hs_addr == 64'h184);
    end
    if (!found) chk("t5_hs_timeout", 1'b0, 1'b1);
    step();
    flush_target = 64'h200; flush_req = 1'b1; step();
    chk("coinc_rsp", imem_rsp_valid, 1'b1);
    chk("coinc_q_nonempty", if_valid, 1'b1);
    step(); chk("coinc_q_empty", if_valid, 1'b0);
    chk("coinc_req", imem_req_valid, 1'b1); chk("coinc_addr", imem_addr, 64'h200);
    dec_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (if_valid) begin found = 1'b1; chk("coinc_next_pc", if_pc, 64'h200); end
    end
    if (!found) chk("coinc_timeout", 1'b0, 1'b1);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned PC becomes a fault entry without a memory read.
    lat_min = 1; lat_max = 1; rdy_pct = 0;
    repeat (6) step();
    dec_pct = 0; rdy_pct = 100;
    flush_target = 64'h6; flush_req = 1'b1; step();
    step(); chk("mis_no_req", imem_req_valid, 1'b0); chk("mis_no_stall", pc_stall, 1'b0);
    step(); chk("mis_valid", if_valid, 1'b1); chk("mis_pc", if_pc, 64'h6);
    chk("mis_fault", if_fault, 1'b1); chk("mis_insn", if_insn, 32'h0);
`endif

    // Randomized traffic against the in-order stream model.
    flush_target = 64'h300; flush_req = 1'b1;
    rdy_pct = 70; dec_pct = 60; lat_min = 1; lat_max = 3; flush_pml = 15;
    repeat (3000) step();
    flush_pml = 0; rdy_pct = 100; dec_pct = 100;
    repeat (20) step();
    chk("progress", npop > 200, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
